// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Round-robin successor of ptr in a ring of n positions.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational rotating-priority encoder: first set request at or above i_start, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_any_valid,
    output logic [IDX_W-1:0]   o_index
);
    logic             w_hi_hit;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Descending scan leaves the lowest hit in each half: at/above start, and overall.
    always_comb begin
        w_hi_hit    = 1'b0;
        w_hi_idx    = '0;
        w_lo_idx    = '0;
        o_any_valid = |i_req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_lo_idx = IDX_W'(k);
                if (IDX_W'(k) >= i_start) begin
                    w_hi_hit = 1'b1;
                    w_hi_idx = IDX_W'(k);
                end
            end
        end
        o_index = w_hi_hit ? w_hi_idx : w_lo_idx;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ack producers.
// Grants last up to MAX_BURST words; one arbitration cycle separates consecutive owners.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_fifo_write,
    output logic [DATA_WIDTH-1:0]         o_fifo_write_data,
    input  logic                          i_fifo_full
);
    localparam int unsigned      IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned      CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [NUM_REQ-1:0]  r_grant;

    logic                w_any;
    logic [IDX_W-1:0]    w_pick;
    logic                w_owner_req;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                w_xfer;
    logic                w_release;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req       (i_req),
        .i_start     (r_rr_ptr),
        .o_any_valid (w_any),
        .o_index     (w_pick)
    );

    // Owner's request bit and data slice.
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == IDX_W'(k)) begin
                w_owner_req  = i_req[k];
                w_owner_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer    = (r_state == ARB_GRANT) && w_owner_req && !i_fifo_full;
    assign w_release = (r_state == ARB_GRANT) &&
                       ((w_xfer && (r_beat_cnt == LAST_BEAT)) || !w_owner_req);

    always_comb begin
        o_ack = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_ack[k] = w_xfer && (r_owner == IDX_W'(k));
        end
    end

    assign o_fifo_write      = w_xfer;
    assign o_fifo_write_data = w_xfer ? w_owner_data : '0;
    assign o_grant           = r_grant;
    assign o_busy            = (r_state == ARB_GRANT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_grant    <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state    <= ARB_GRANT;
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                        r_grant    <= NUM_REQ'(1) << w_pick;
                    end
                end
                ARB_GRANT: begin
                    if (w_release) begin
                        r_state    <= ARB_IDLE;
                        r_rr_ptr   <= IDX_W'(rr_next(32'(r_owner), NUM_REQ));
                        r_beat_cnt <= '0;
                        r_grant    <= '0;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a behavioural 16-entry FIFO and write scoreboard.
module tb_fifo_write_arbiter;
    localparam int unsigned FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        fwr;
    logic [7:0]  fwd;
    logic        ffull;

    logic [1:0]  b_req;
    logic [15:0] b_data;
    logic [1:0]  b_ack;
    logic [1:0]  b_grant;
    logic        b_busy;
    logic        b_wr;
    logic [7:0]  b_wd;
    logic        b_full;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  b_q[$];
    logic [7:0]  exp_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req             (req),
        .i_req_data        (req_data),
        .o_ack             (ack),
        .o_grant           (grant),
        .o_busy            (busy),
        .o_fifo_write      (fwr),
        .o_fifo_write_data (fwd),
        .i_fifo_full       (ffull)
    );

    fifo_write_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut_b (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req             (b_req),
        .i_req_data        (b_data),
        .o_ack             (b_ack),
        .o_grant           (b_grant),
        .o_busy            (b_busy),
        .o_fifo_write      (b_wr),
        .o_fifo_write_data (b_wd),
        .i_fifo_full       (b_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture writes presented at the edge into the FIFO models.
    task automatic tick();
        logic       w;
        logic       bw;
        logic       full_s;
        logic [7:0] d;
        logic [7:0] bd;
        w      = fwr;
        d      = fwd;
        bw     = b_wr;
        bd     = b_wd;
        full_s = ffull;
        if (w) chk("write_while_full", 32'(full_s), 32'(0));
        @(posedge clk);
        if (w) fifo_q.push_back(d);
        if (bw) b_q.push_back(bd);
        #1;
        ffull = (fifo_q.size() >= FIFO_DEPTH);
    endtask

    task automatic cyc(input string tag, input logic [3:0] g, input logic [3:0] a, input logic [7:0] d);
        #1;
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"},  32'(busy),  32'(g != 4'd0));
        chk({tag, ".ack"},   32'(ack),   32'(a));
        chk({tag, ".write"}, 32'(fwr),   32'(a != 4'd0));
        chk({tag, ".wdata"}, 32'(fwd),   32'(d));
        if (a != 4'd0) exp_q.push_back(d);
        tick();
    endtask

    task automatic cyc_b(input string tag, input logic [1:0] g, input logic [7:0] d);
        #1;
        chk({tag, ".grant"}, 32'(b_grant), 32'(g));
        chk({tag, ".ack"},   32'(b_ack),   32'(g));
        chk({tag, ".write"}, 32'(b_wr),    32'(g != 2'd0));
        chk({tag, ".wdata"}, 32'(b_wd),    32'(d));
        if (g != 2'd0) exp_b.push_back(d);
        tick();
    endtask

    task automatic drain_n(input string tag, input int n);
        logic [7:0] got;
        logic [7:0] want;
        for (int i = 0; i < n; i++) begin
            if (fifo_q.size() == 0 || exp_q.size() == 0) begin
                chk({tag, ".underflow"}, 32'(fifo_q.size()), 32'(exp_q.size()));
                break;
            end
            got  = fifo_q.pop_front();
            want = exp_q.pop_front();
            chk($sformatf("%s.rd%0d", tag, i), 32'(got), 32'(want));
        end
        ffull = (fifo_q.size() >= FIFO_DEPTH);
    endtask

    task automatic drain_all(input string tag);
        chk({tag, ".count"}, 32'(fifo_q.size()), 32'(exp_q.size()));
        drain_n(tag, (fifo_q.size() < exp_q.size()) ? fifo_q.size() : exp_q.size());
        fifo_q.delete();
        exp_q.delete();
        ffull = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        b_req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        req_data = 32'hFFFF_FFFF;
        b_req    = '0;
        b_data   = 16'hB1B0;
        b_full   = 1'b0;
        ffull    = 1'b0;
        tick();
        cyc("reset", 4'b0000, 4'b0000, 8'h00);
        rst = 1'b0;
        req = '0;
        tick();

        // Single requester: 4-beat burst, one idle cycle, re-grant of the same requester.
        req      = 4'b0100;
        req_data = 32'h11A5_3344;
        cyc("t1_arb", 4'b0000, 4'b0000, 8'h00);
        for (int i = 1; i <= 4; i++) cyc($sformatf("t1_beat%0d", i), 4'b0100, 4'b0100, 8'hA5);
        chk("t1_fifo_count", 32'(fifo_q.size()), 32'(4));
        cyc("t1_release", 4'b0000, 4'b0000, 8'h00);
        cyc("t1_regrant", 4'b0100, 4'b0100, 8'hA5);
        req = '0;
        cyc("t1_drop", 4'b0100, 4'b0000, 8'h00);
        cyc("t1_idle", 4'b0000, 4'b0000, 8'h00);
        drain_all("t1");

        // All requesting: fair rotation 0,1,2,3,0 with one idle cycle between bursts.
        do_reset();
        req      = 4'b1111;
        req_data = 32'h4332_2110;
        for (int b = 0; b < 5; b++) begin
            logic [3:0] g;
            logic [7:0] d;
            g = 4'b0001 << (b % 4);
            d = 8'h10 + 8'((b % 4) * 8'h11);
            drain_all($sformatf("t2_burst%0d", b));
            cyc($sformatf("t2_idle%0d", b), 4'b0000, 4'b0000, 8'h00);
            for (int i = 0; i < 4; i++) cyc($sformatf("t2_b%0d_w%0d", b, i), g, g, d);
        end
        req = '0;
        cyc("t2_end", 4'b0000, 4'b0000, 8'h00);
        drain_all("t2_last");

        // Full stall: grant held, no ack, counter frozen; burst resumes after draining.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            fifo_q.push_back(8'hE0 + 8'(i));
            exp_q.push_back(8'hE0 + 8'(i));
        end
        ffull    = (fifo_q.size() >= FIFO_DEPTH);
        req      = 4'b0010;
        req_data = 32'h9988_5C77;
        cyc("t3_arb", 4'b0000, 4'b0000, 8'h00);
        cyc("t3_w0", 4'b0010, 4'b0010, 8'h5C);
        chk("t3_full", 32'(ffull), 32'(1));
        for (int i = 0; i < 5; i++) cyc($sformatf("t3_stall%0d", i), 4'b0010, 4'b0000, 8'h00);
        drain_n("t3_drain2", 2);
        cyc("t3_w1", 4'b0010, 4'b0010, 8'h5C);
        cyc("t3_w2", 4'b0010, 4'b0010, 8'h5C);
        cyc("t3_stall_again", 4'b0010, 4'b0000, 8'h00);
        drain_n("t3_drain1", 1);
        cyc("t3_w3", 4'b0010, 4'b0010, 8'h5C);
        req = '0;
        cyc("t3_release", 4'b0000, 4'b0000, 8'h00);
        chk("t3_fifo_count", 32'(fifo_q.size()), 32'(16));
        drain_all("t3");

        // Owner 3 drops after 2 words; pointer wraps and requester 0 follows.
        do_reset();
        req      = 4'b1000;
        req_data = 32'h3D00_000F;
        cyc("t4_arb", 4'b0000, 4'b0000, 8'h00);
        cyc("t4_w0", 4'b1000, 4'b1000, 8'h3D);
        cyc("t4_w1", 4'b1000, 4'b1000, 8'h3D);
        req = 4'b0001;
        cyc("t4_drop", 4'b1000, 4'b0000, 8'h00);
        cyc("t4_idle", 4'b0000, 4'b0000, 8'h00);
        cyc("t4_g0", 4'b0001, 4'b0001, 8'h0F);
        req = '0;
        cyc("t4_drop0", 4'b0001, 4'b0000, 8'h00);
        cyc("t4_end", 4'b0000, 4'b0000, 8'h00);
        drain_all("t4");

        // Reset mid-burst clears everything at once; pointer restarts at 0.
        do_reset();
        req      = 4'b0100;
        req_data = 32'h0077_6100;
        cyc("t5_arb", 4'b0000, 4'b0000, 8'h00);
        cyc("t5_w0", 4'b0100, 4'b0100, 8'h77);
        cyc("t5_w1", 4'b0100, 4'b0100, 8'h77);
        rst = 1'b1;
        cyc("t5_in_reset", 4'b0000, 4'b0000, 8'h00);
        rst = 1'b0;
        req = 4'b0110;
        cyc("t5_arb2", 4'b0000, 4'b0000, 8'h00);
        cyc("t5_g1", 4'b0010, 4'b0010, 8'h61);
        req = '0;
        cyc("t5_drop", 4'b0010, 4'b0000, 8'h00);
        cyc("t5_end", 4'b0000, 4'b0000, 8'h00);
        drain_all("t5");

        // MAX_BURST=1, two requesters: single-word grants alternating every other cycle.
        do_reset();
        b_req = 2'b11;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                cyc_b($sformatf("t6_idle%0d", c), 2'b00, 8'h00);
            end else begin
                logic o;
                o = 1'((c / 2) % 2);
                cyc_b($sformatf("t6_grant%0d", c), 2'b01 << o, o ? 8'hB1 : 8'hB0);
            end
        end
        b_req = '0;
        tick();
        tick();
        chk("t6_count", 32'(b_q.size()), 32'(exp_b.size()));
        while (b_q.size() > 0 && exp_b.size() > 0) begin
            logic [7:0] got;
            logic [7:0] want;
            got  = b_q.pop_front();
            want = exp_b.pop_front();
            chk("t6_readback", 32'(got), 32'(want));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
